// File: rtl/mac_array_pkg.sv
// Shared types, width helpers and the saturating narrower for the multi-lane MAC array.
package mac_array_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } frame_state_t;

    localparam int DEF_LANES      = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int NARROW_MAX_W   = 128;

    function automatic int calc_prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int calc_sum_width(input int data_width, input int lanes);
        return calc_prod_width(data_width) + $clog2(lanes);
    endfunction

    localparam int PROD_WIDTH = calc_prod_width(DEF_DATA_WIDTH);
    localparam int SUM_WIDTH  = calc_sum_width(DEF_DATA_WIDTH, DEF_LANES);

    typedef struct packed {
        logic signed [NARROW_MAX_W-1:0] value;
        logic                           sat;
    } narrow_t;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic narrow_t sat_narrow(input logic signed [NARROW_MAX_W-1:0] value,
                                           input int width);
        logic signed [NARROW_MAX_W-1:0] lim_hi;
        logic signed [NARROW_MAX_W-1:0] lim_lo;
        narrow_t                        res;
        for (int i = 0; i < NARROW_MAX_W; i++) begin
            lim_hi[i] = (i < width - 1) ? 1'b1 : 1'b0;
            lim_lo[i] = (i < width - 1) ? 1'b0 : 1'b1;
        end
        if (value > lim_hi) begin
            res.value = lim_hi;
            res.sat   = 1'b1;
        end else if (value < lim_lo) begin
            res.value = lim_lo;
            res.sat   = 1'b1;
        end else begin
            res.value = value;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_array_unit_tree.sv
// Registered signed reduction of LANES packed products (second pipeline stage).
module mac_adder_tree #(
    parameter int LANES      = 4,
    parameter int PROD_WIDTH = mac_array_pkg::PROD_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_en,
    input  logic [LANES*PROD_WIDTH-1:0]             i_prod,
    output logic [PROD_WIDTH+$clog2(LANES)-1:0]     o_sum
);

    localparam int SUM_WIDTH = PROD_WIDTH + $clog2(LANES);

    logic signed [SUM_WIDTH-1:0] w_tree_sum;
    logic signed [SUM_WIDTH-1:0] r_sum;

    // Sign-extend every lane product and reduce to a single sum.
    always_comb begin
        w_tree_sum = {SUM_WIDTH{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_tree_sum = w_tree_sum + SUM_WIDTH'($signed(i_prod[i*PROD_WIDTH +: PROD_WIDTH]));
        end
    end

    // Sum register, held while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= {SUM_WIDTH{1'b0}};
        end else if (i_en) begin
            r_sum <= w_tree_sum;
        end else begin
            r_sum <= r_sum;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/mac_array_unit.sv
// Streamed multi-lane dot-product accumulator with framed results over valid/ready.
// Optional output clamping is enabled by defining MAC_ARRAY_SAT_EN.
module mac_array_unit
    import mac_array_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 32,
    parameter int FRAC_SHIFT  = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    input  logic                          in_first,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [COUNT_WIDTH-1:0]        out_count,
    output logic                          out_sat,
    output logic                          out_frame_err
);

    localparam int L_PROD_W = calc_prod_width(DATA_WIDTH);
    localparam int L_SUM_W  = calc_sum_width(DATA_WIDTH, LANES);

    // rst is active-low throughout.
    logic                          w_advance;
    logic [LANES*L_PROD_W-1:0]     w_prod;
    logic [LANES*L_PROD_W-1:0]     r_p1_prod;
    logic                          r_p1_valid;
    logic                          r_p1_first;
    logic                          r_p1_last;
    logic                          r_p2_valid;
    logic                          r_p2_first;
    logic                          r_p2_last;
    logic signed [L_SUM_W-1:0]     w_sum;

    frame_state_t                  r_state;
    frame_state_t                  w_state_next;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [COUNT_WIDTH-1:0]        r_count;
    logic                          r_err;

    logic                          w_p3_fire;
    logic                          w_eff_first;
    logic                          w_err_beat;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic [COUNT_WIDTH-1:0]        w_count_next;
    logic                          w_err_next;
    logic [OUT_WIDTH-1:0]          w_out_data_next;
    logic                          w_out_sat_next;

    logic                          r_out_valid;
    logic [OUT_WIDTH-1:0]          r_out_data;
    logic [COUNT_WIDTH-1:0]        r_out_count;
    logic                          r_out_sat;
    logic                          r_out_err;

`ifdef MAC_ARRAY_SAT_EN
    narrow_t                       w_narrow;
    logic                          w_unused_narrow_hi;
    assign w_unused_narrow_hi = ^w_narrow.value[NARROW_MAX_W-1:OUT_WIDTH];
`else
    logic                          w_unused_shift_hi;
    assign w_unused_shift_hi = ^w_shifted[ACC_WIDTH-1:OUT_WIDTH];
`endif

    assign w_advance = !(r_out_valid && !out_ready);
    assign in_ready  = w_advance;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_prod[g*L_PROD_W +: L_PROD_W] =
            L_PROD_W'($signed(in_a[g*DATA_WIDTH +: DATA_WIDTH])) *
            L_PROD_W'($signed(in_b[g*DATA_WIDTH +: DATA_WIDTH]));
    end

    // Stage 1: lane products plus framing sideband; an accepted beat is simply in_valid while advancing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_prod  <= {(LANES*L_PROD_W){1'b0}};
            r_p1_valid <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
        end else if (w_advance) begin
            r_p1_prod  <= w_prod;
            r_p1_valid <= in_valid;
            r_p1_first <= in_first;
            r_p1_last  <= in_last;
        end else begin
            r_p1_prod  <= r_p1_prod;
            r_p1_valid <= r_p1_valid;
            r_p1_first <= r_p1_first;
            r_p1_last  <= r_p1_last;
        end
    end

    mac_adder_tree #(
        .LANES      (LANES),
        .PROD_WIDTH (L_PROD_W)
    ) u_tree (
        .clk    (clk),
        .rst_n  (rst),
        .i_en   (w_advance),
        .i_prod (r_p1_prod),
        .o_sum  (w_sum)
    );

    // Stage 2 sideband travelling alongside the tree sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p2_valid <= 1'b0;
            r_p2_first <= 1'b0;
            r_p2_last  <= 1'b0;
        end else if (w_advance) begin
            r_p2_valid <= r_p1_valid;
            r_p2_first <= r_p1_first;
            r_p2_last  <= r_p1_last;
        end else begin
            r_p2_valid <= r_p2_valid;
            r_p2_first <= r_p2_first;
            r_p2_last  <= r_p2_last;
        end
    end

    // Stage 3 next-state: framing decisions, accumulation and output narrowing.
    always_comb begin
        w_p3_fire       = w_advance && r_p2_valid;
        w_eff_first     = r_p2_first || (r_state == IDLE);
        w_err_beat      = (!r_p2_first && (r_state == IDLE)) || (r_p2_first && (r_state == ACC));
        w_acc_next      = (w_eff_first ? {ACC_WIDTH{1'b0}} : r_acc) + ACC_WIDTH'(w_sum);
        w_shifted       = w_acc_next >>> FRAC_SHIFT;
        w_err_next      = r_err | w_err_beat;
        w_state_next    = r_state;
        w_out_data_next = {OUT_WIDTH{1'b0}};
        w_out_sat_next  = 1'b0;

        if (w_eff_first) begin
            w_count_next = COUNT_WIDTH'(1);
        end else if (r_count == {COUNT_WIDTH{1'b1}}) begin
            w_count_next = r_count;
        end else begin
            w_count_next = r_count + COUNT_WIDTH'(1);
        end

`ifdef MAC_ARRAY_SAT_EN
        w_narrow        = sat_narrow(NARROW_MAX_W'(w_shifted), OUT_WIDTH);
        w_out_data_next = w_narrow.value[OUT_WIDTH-1:0];
        w_out_sat_next  = w_narrow.sat;
`else
        w_out_data_next = w_shifted[OUT_WIDTH-1:0];
        w_out_sat_next  = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (w_p3_fire && !r_p2_last) begin
                    w_state_next = ACC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            ACC: begin
                if (w_p3_fire && r_p2_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = ACC;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulator, beat count and sticky framing error; the error clears once its result is emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= {ACC_WIDTH{1'b0}};
            r_count <= {COUNT_WIDTH{1'b0}};
            r_err   <= 1'b0;
        end else if (w_p3_fire) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_err   <= r_p2_last ? 1'b0 : w_err_next;
        end else begin
            r_acc   <= r_acc;
            r_count <= r_count;
            r_err   <= r_err;
        end
    end

    // Result register: a new result may load in the same cycle the previous one is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {OUT_WIDTH{1'b0}};
            r_out_count <= {COUNT_WIDTH{1'b0}};
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_p3_fire && r_p2_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data_next;
            r_out_count <= w_count_next;
            r_out_sat   <= w_out_sat_next;
            r_out_err   <= w_err_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_count     = r_out_count;
    assign out_sat       = r_out_sat;
    assign out_frame_err = r_out_err;

endmodule
